// File: rtl/serial_sub_pkg.sv
// Shared types and the single-bit subtract equation for the serial subtractor.
package serial_sub_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic d;
    logic borrow;
  } sub_bit_t;

  // One bit of a - b - borrow_in: difference bit and borrow out.
  function automatic sub_bit_t sub_bit(input logic a, input logic b, input logic borrow_in);
    sub_bit_t r;
    r.d      = a ^ b ^ borrow_in;
    r.borrow = (~a & b) | (~(a ^ b) & borrow_in);
    return r;
  endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// Combinational full-subtractor cell: d = a ^ b ^ bin, bout is the borrow out.
// Holds no state; the borrow register lives in the serial wrapper.
module full_subtractor_cell
  import serial_sub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  sub_bit_t res;

  assign res  = sub_bit(a, b, bin);
  assign d    = res.d;
  assign bout = res.borrow;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, D = A - B mod 2^WIDTH, LSB first.
// One full-subtractor cell with a registered borrow; ready/valid on both sides
// and a single output register (no skid buffer), so in_ready follows out_ready.
//
// state | meaning
// IDLE  | waiting for bit 0 of a new word
// RUN   | word in progress, bits 1..WIDTH-1 still to come
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
)
(
  input  logic CLK,
  input  logic ASYNCRESET,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_a,
  input  logic in_b,
  output logic out_valid,
  input  logic out_ready,
  output logic out_d,
  output logic out_last,
  output logic out_borrow,
  output logic out_zero,
  output logic busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] bit_cnt_q;
  logic             borrow_q;
  logic             zero_acc_q;
  logic             accept;
  logic             last_bit;
  logic             next_d;
  logic             next_borrow;

  full_subtractor_cell u_cell (
    .a    (in_a),
    .b    (in_b),
    .bin  (borrow_q),
    .d    (next_d),
    .bout (next_borrow)
  );

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign last_bit = (bit_cnt_q == LAST_IDX);
  assign busy     = (state_q == RUN);

  // State register.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a word starts on the first accepted bit and ends on the last one.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && (bit_cnt_q == '0)) state_d = RUN;
      RUN:  if (accept && last_bit)          state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Word bookkeeping: bit counter, running borrow and zero accumulator.
  // All three return to their start values after the last bit so back-to-back
  // words see a clean slate without an idle beat.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      bit_cnt_q  <= '0;
      borrow_q   <= 1'b0;
      zero_acc_q <= 1'b1;
    end else if (accept) begin
      if (last_bit) begin
        bit_cnt_q  <= '0;
        borrow_q   <= 1'b0;
        zero_acc_q <= 1'b1;
      end else begin
        bit_cnt_q  <= bit_cnt_q + CNT_W'(1);
        borrow_q   <= next_borrow;
        zero_acc_q <= zero_acc_q & ~next_d;
      end
    end
  end

  // Output register: loads on accept, drops valid when drained, holds while stalled.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      out_valid  <= 1'b0;
      out_d      <= 1'b0;
      out_last   <= 1'b0;
      out_borrow <= 1'b0;
      out_zero   <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_d      <= next_d;
      out_last   <= last_bit;
      out_borrow <= last_bit & next_borrow;
      out_zero   <= last_bit & zero_acc_q & ~next_d;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8) with a beat scoreboard.
module tb_serial_subtractor;

  logic CLK = 1'b0;
  logic ASYNCRESET;
  logic in_valid, in_ready, in_a, in_b;
  logic out_valid, out_ready, out_d, out_last, out_borrow, out_zero, busy;

  typedef struct packed {
    logic d;
    logic last;
    logic borrow;
    logic zero;
  } beat_t;

  beat_t exp_q[$];
  beat_t obs_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  logic  stall_ready_seen, stall_valid_lost, stall_unstable;
  int    first_out_cyc, last_out_cyc;

  serial_subtractor #(.WIDTH(8)) dut (
    .CLK        (CLK),
    .ASYNCRESET (ASYNCRESET),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_d      (out_d),
    .out_last   (out_last),
    .out_borrow (out_borrow),
    .out_zero   (out_zero),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  // One clock: inputs are applied just after a rising edge, observed on the falling edge.
  task automatic drive_cycle(input logic v, input logic a, input logic b, input logic rdy,
                             output logic acc, output logic got, output beat_t obs,
                             output logic ir, output logic ov);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    out_ready = rdy;
    @(negedge CLK);
    ir  = in_ready;
    ov  = out_valid;
    acc = v && in_ready;
    got = out_valid && rdy;
    obs = '{d: out_d, last: out_last, borrow: out_borrow, zero: out_zero};
    @(posedge CLK);
    #1;
  endtask

  // Streams up to two words; expected beats are pushed from plain arithmetic on accept.
  task automatic stream(input logic [7:0] a0, input logic [7:0] b0,
                        input logic [7:0] a1, input logic [7:0] b1,
                        input int nwords, input int stall_at, input int stall_len);
    logic [7:0] wa, wb, diff;
    int    wi = 0, bi = 0, n_out = 0, cyc = 0, stall_left = 0;
    bit    stall_done = 0;
    beat_t stall_ref = '0;
    beat_t obs, e;
    logic  acc, got, ir, ov, rdy;
    stall_ready_seen = 0;
    stall_valid_lost = 0;
    stall_unstable   = 0;
    first_out_cyc    = -1;
    last_out_cyc     = -1;
    while (n_out < nwords * 8 && cyc < 200) begin
      wa = (wi == 0) ? a0 : a1;
      wb = (wi == 0) ? b0 : b1;
      if (!stall_done && stall_len > 0 && n_out == stall_at) begin
        stall_left = stall_len;
        stall_done = 1;
      end
      rdy = (stall_left == 0);
      drive_cycle(wi < nwords, wa[bi], wb[bi], rdy, acc, got, obs, ir, ov);
      if (!rdy) begin
        if (stall_left == stall_len) stall_ref = obs;
        else if (obs !== stall_ref) stall_unstable = 1;
        if (ir) stall_ready_seen = 1;
        if (!ov) stall_valid_lost = 1;
        stall_left--;
      end
      if (acc) begin
        diff     = wa - wb;
        e.d      = diff[bi];
        e.last   = (bi == 7);
        e.borrow = e.last && (wa < wb);
        e.zero   = e.last && (diff == 8'h00);
        exp_q.push_back(e);
        bi++;
        if (bi == 8) begin
          bi = 0;
          wi++;
        end
      end
      if (got) begin
        obs_q.push_back(obs);
        if (first_out_cyc < 0) first_out_cyc = cyc;
        last_out_cyc = cyc;
        n_out++;
      end
      cyc++;
    end
    in_valid  = 0;
    out_ready = 1;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({out_valid, out_d, out_last, out_borrow, out_zero, busy} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 000000",
               {out_valid, out_d, out_last, out_borrow, out_zero, busy});
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_basic();
    beat_t e, o;
    logic [7:0] word = '0;
    int k = 0;
    stream(8'h5A, 8'h3C, 8'h00, 8'h00, 1, 0, 0);
    n_checks++;
    if (obs_q.size() != 8) begin
      n_fail++;
      $display("FAIL basic_beats: got %0d expected 8", obs_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL basic_beat%0d: got none expected %b", k, e);
      end else begin
        o = obs_q.pop_front();
        word[k % 8] = o.d;
        if (o !== e) begin
          n_fail++;
          $display("FAIL basic_beat%0d: got %b expected %b", k, o, e);
        end
      end
      k++;
    end
    n_checks++;
    if (word !== 8'h1E) begin
      n_fail++;
      $display("FAIL basic_word: got %h expected 1e", word);
    end
    n_checks++;
    if (last_out_cyc - first_out_cyc != 7) begin
      n_fail++;
      $display("FAIL basic_throughput: got span %0d expected 7", last_out_cyc - first_out_cyc);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_busy_after: got %b expected 0", busy);
    end
  endtask

  task automatic test_underflow();
    beat_t e, o;
    logic [7:0] word = '0;
    int k = 0;
    stream(8'h03, 8'h05, 8'h00, 8'h00, 1, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL under_beat%0d: got none expected %b", k, e);
      end else begin
        o = obs_q.pop_front();
        word[k % 8] = o.d;
        if (o !== e) begin
          n_fail++;
          $display("FAIL under_beat%0d: got %b expected %b", k, o, e);
        end
        if (k == 7) begin
          n_checks++;
          if ({o.last, o.borrow, o.zero} !== 3'b110) begin
            n_fail++;
            $display("FAIL under_flags: got %b expected 110", {o.last, o.borrow, o.zero});
          end
        end
      end
      k++;
    end
    n_checks++;
    if (word !== 8'hFE) begin
      n_fail++;
      $display("FAIL under_word: got %h expected fe", word);
    end
  endtask

  task automatic test_zero();
    beat_t e, o;
    logic [7:0] word = 8'hFF;
    int k = 0;
    stream(8'h77, 8'h77, 8'h00, 8'h00, 1, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL zero_beat%0d: got none expected %b", k, e);
      end else begin
        o = obs_q.pop_front();
        word[k % 8] = o.d;
        if (o !== e) begin
          n_fail++;
          $display("FAIL zero_beat%0d: got %b expected %b", k, o, e);
        end
        if (k == 7) begin
          n_checks++;
          if ({o.last, o.borrow, o.zero} !== 3'b101) begin
            n_fail++;
            $display("FAIL zero_flags: got %b expected 101", {o.last, o.borrow, o.zero});
          end
        end
      end
      k++;
    end
    n_checks++;
    if (word !== 8'h00) begin
      n_fail++;
      $display("FAIL zero_word: got %h expected 00", word);
    end
  endtask

  task automatic test_stall();
    beat_t e, o;
    logic [7:0] word = '0;
    int k = 0;
    stream(8'h5A, 8'h3C, 8'h00, 8'h00, 1, 3, 3);
    n_checks++;
    if (stall_ready_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_in_ready: got in_ready=1 during stall expected 0");
    end
    n_checks++;
    if (stall_unstable !== 1'b0 || stall_valid_lost !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_hold: got unstable=%b valid_lost=%b expected 0 0",
               stall_unstable, stall_valid_lost);
    end
    n_checks++;
    if (obs_q.size() != 8) begin
      n_fail++;
      $display("FAIL stall_beats: got %0d expected 8", obs_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL stall_beat%0d: got none expected %b", k, e);
      end else begin
        o = obs_q.pop_front();
        word[k % 8] = o.d;
        if (o !== e) begin
          n_fail++;
          $display("FAIL stall_beat%0d: got %b expected %b", k, o, e);
        end
      end
      k++;
    end
    n_checks++;
    if (word !== 8'h1E) begin
      n_fail++;
      $display("FAIL stall_word: got %h expected 1e", word);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] wa = 8'h03, wb = 8'h05;
    logic acc, got, ir, ov;
    beat_t obs, e, o;
    logic [7:0] word = '0;
    int k = 0;
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, wa[i], wb[i], 1'b1, acc, got, obs, ir, ov);
    n_checks++;
    if ({busy, out_valid} !== 2'b11) begin
      n_fail++;
      $display("FAIL midreset_busy_before: got %b expected 11", {busy, out_valid});
    end
    in_valid = 0;
    #2;
    ASYNCRESET = 1;
    #1;
    n_checks++;
    if ({out_valid, out_d, out_last, out_borrow, out_zero, busy} !== 6'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %b expected 000000",
               {out_valid, out_d, out_last, out_borrow, out_zero, busy});
    end
    #3;
    ASYNCRESET = 0;
    @(posedge CLK);
    #1;
    exp_q.delete();
    obs_q.delete();
    stream(8'h5A, 8'h3C, 8'h00, 8'h00, 1, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL midreset_beat%0d: got none expected %b", k, e);
      end else begin
        o = obs_q.pop_front();
        word[k % 8] = o.d;
        if (o !== e) begin
          n_fail++;
          $display("FAIL midreset_beat%0d: got %b expected %b", k, o, e);
        end
      end
      k++;
    end
    n_checks++;
    if (word !== 8'h1E) begin
      n_fail++;
      $display("FAIL midreset_word: got %h expected 1e", word);
    end
  endtask

  task automatic test_back_to_back();
    beat_t e, o;
    logic [15:0] words = '0;
    logic [1:0]  borrows = '0;
    int k = 0;
    stream(8'h00, 8'h01, 8'h01, 8'h00, 2, 0, 0);
    n_checks++;
    if (obs_q.size() != 16 || last_out_cyc - first_out_cyc != 15) begin
      n_fail++;
      $display("FAIL b2b_consecutive: got %0d beats over span %0d expected 16 over 15",
               obs_q.size(), last_out_cyc - first_out_cyc);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL b2b_beat%0d: got none expected %b", k, e);
      end else begin
        o = obs_q.pop_front();
        words[k % 16] = o.d;
        if (k == 7)  borrows[0] = o.borrow;
        if (k == 15) borrows[1] = o.borrow;
        if (o !== e) begin
          n_fail++;
          $display("FAIL b2b_beat%0d: got %b expected %b", k, o, e);
        end
      end
      k++;
    end
    n_checks++;
    if (words !== 16'h01FF || borrows !== 2'b01) begin
      n_fail++;
      $display("FAIL b2b_words: got %h borrows %b expected 01ff borrows 01", words, borrows);
    end
  endtask

  initial begin
    ASYNCRESET = 1;
    in_valid   = 0;
    in_a       = 0;
    in_b       = 0;
    out_ready  = 1;
    repeat (2) @(posedge CLK);
    #3;
    test_reset();
    ASYNCRESET = 0;
    @(posedge CLK);
    #1;
    test_reset();
    test_basic();
    test_underflow();
    test_zero();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
